// File: rtl/vexriscv_soc_pkg.sv
// Shared types for the VexRiscv SoC bus fabric: arbiter FSM states, access
// size encodings and response-owner encoding.
package vexriscv_soc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_BAD  = 2'd3
  } size_t;

  typedef enum logic {
    OWNER_DBUS = 1'b0,
    OWNER_IBUS = 1'b1
  } owner_t;

endpackage

// File: rtl/vexriscv_bus_arbiter_if.sv
// CPU iBus/dBus and shared memory port bundle. The slave modport is the
// arbiter's view; the master modport is the CPU-plus-memory side.
interface vexriscv_bus_arbiter_if #(
  parameter int MEM_AW = 20
);
  logic              ibus_cmd_valid;
  logic              ibus_cmd_ready;
  logic [31:0]       ibus_cmd_pc;
  logic              ibus_rsp_valid;
  logic              ibus_rsp_error;
  logic [31:0]       ibus_rsp_inst;

  logic              dbus_cmd_valid;
  logic              dbus_cmd_ready;
  logic              dbus_cmd_wr;
  logic [31:0]       dbus_cmd_address;
  logic [31:0]       dbus_cmd_data;
  logic [1:0]        dbus_cmd_size;
  logic              dbus_rsp_ready;
  logic              dbus_rsp_error;
  logic [31:0]       dbus_rsp_data;

  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_wr;
  logic [MEM_AW-1:0] mem_cmd_addr;
  logic [31:0]       mem_cmd_wdata;
  logic [3:0]        mem_cmd_mask;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;

  modport slave (
    input  ibus_cmd_valid, ibus_cmd_pc,
    output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
    input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
    output dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_error, dbus_rsp_data,
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_mask,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport master (
    output ibus_cmd_valid, ibus_cmd_pc,
    input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error, ibus_rsp_inst,
    output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
    input  dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_error, dbus_rsp_data,
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_mask,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/vexriscv_bus_lanes.sv
// Combinational byte-lane steering: word address, byte mask, replicated write
// data, and alignment / address-range error for one bus request.
module vexriscv_bus_lanes
  import vexriscv_soc_pkg::*;
#(
  parameter int MEM_AW = 20
) (
  input  logic [31:0]       addr,
  input  size_t             size,
  input  logic [31:0]       wdata,
  output logic [MEM_AW-1:0] word_addr,
  output logic [3:0]        mask,
  output logic [31:0]       wdata_lanes,
  output logic              error
);

  logic range_err;
  logic align_err;

  assign word_addr = addr[MEM_AW+1:2];
  assign range_err = (addr >> (MEM_AW + 2)) != 32'd0;

  always_comb begin
    case (size)
      SIZE_BYTE: align_err = 1'b0;
      SIZE_HALF: align_err = addr[0];
      SIZE_WORD: align_err = addr[1] | addr[0];
      default:   align_err = 1'b1;
    endcase
  end

  assign error = range_err | align_err;

  // Narrow writes are replicated so the enabled lane always sees the datum.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign mask[gi] = (size == SIZE_WORD)
                    | ((size == SIZE_HALF) & (addr[1] == 1'(gi / 2)))
                    | ((size == SIZE_BYTE) & (addr[1:0] == 2'(gi)));
    assign wdata_lanes[gi*8 +: 8] = (size == SIZE_BYTE) ? wdata[7:0] :
                                    (size == SIZE_HALF) ? wdata[(gi % 2)*8 +: 8] :
                                                          wdata[gi*8 +: 8];
  end

endmodule

// File: rtl/vexriscv_bus_arbiter.sv
// Shares one single-port memory between VexRiscv iBus and dBus with at most one
// read in flight. Define BUS_ARB_RR_EN for round-robin instead of dBus priority.
module vexriscv_bus_arbiter
  import vexriscv_soc_pkg::*;
#(
  parameter int MEM_AW = 20
) (
  input logic                   clk,
  input logic                   reset_n,
  vexriscv_bus_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_next;
  owner_t            owner;
  logic              grant_d;
  logic              grant_i;
  logic              any_grant;
  logic              accept;
  logic              is_read;
  logic              deliver;
  logic [31:0]       sel_addr;
  size_t             sel_size;
  logic [MEM_AW-1:0] lane_word_addr;
  logic [3:0]        lane_mask;
  logic [31:0]       lane_wdata;
  logic              lane_err;

`ifdef BUS_ARB_RR_EN
  owner_t prio;

  // Priority flips to the other requester after every accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= OWNER_DBUS;
    end else if (accept) begin
      prio <= grant_d ? OWNER_IBUS : OWNER_DBUS;
    end
  end
`endif

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
`ifdef BUS_ARB_RR_EN
      if (bus.dbus_cmd_valid && bus.ibus_cmd_valid) begin
        grant_d = (prio == OWNER_DBUS);
        grant_i = (prio == OWNER_IBUS);
      end else begin
        grant_d = bus.dbus_cmd_valid;
        grant_i = bus.ibus_cmd_valid;
      end
`else
      grant_d = bus.dbus_cmd_valid;
      grant_i = bus.ibus_cmd_valid & ~bus.dbus_cmd_valid;
`endif
    end
  end

  always_comb begin
    sel_addr = grant_d ? bus.dbus_cmd_address : bus.ibus_cmd_pc;
    sel_size = grant_d ? size_t'(bus.dbus_cmd_size) : SIZE_WORD;
  end

  assign is_read   = ~(grant_d & bus.dbus_cmd_wr);
  assign any_grant = grant_d | grant_i;
  // Faulty commands complete locally, so they never wait on the memory.
  assign accept    = reset_n & any_grant & (lane_err | bus.mem_cmd_ready);

  vexriscv_bus_lanes #(.MEM_AW(MEM_AW)) u_lanes (
    .addr        (sel_addr),
    .size        (sel_size),
    .wdata       (bus.dbus_cmd_data),
    .word_addr   (lane_word_addr),
    .mask        (lane_mask),
    .wdata_lanes (lane_wdata),
    .error       (lane_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_read) begin
          state_next = lane_err ? ERR_RSP : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.mem_rsp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner <= OWNER_DBUS;
    end else if (accept && is_read) begin
      owner <= grant_i ? OWNER_IBUS : OWNER_DBUS;
    end
  end

  always_comb begin
    deliver            = ((state == WAIT_RSP) && bus.mem_rsp_valid) || (state == ERR_RSP);
    bus.ibus_cmd_ready = grant_i & accept;
    bus.dbus_cmd_ready = grant_d & accept;
    bus.mem_cmd_valid  = reset_n & any_grant & ~lane_err;
    bus.mem_cmd_wr     = ~is_read;
    bus.mem_cmd_addr   = lane_word_addr;
    bus.mem_cmd_mask   = lane_mask;
    bus.mem_cmd_wdata  = lane_wdata;
    bus.ibus_rsp_valid = deliver && (owner == OWNER_IBUS);
    bus.ibus_rsp_error = bus.ibus_rsp_valid && (state == ERR_RSP);
    bus.ibus_rsp_inst  = (bus.ibus_rsp_valid && (state == WAIT_RSP)) ? bus.mem_rsp_rdata : 32'd0;
    bus.dbus_rsp_ready = deliver && (owner == OWNER_DBUS);
    bus.dbus_rsp_error = bus.dbus_rsp_ready && (state == ERR_RSP);
    bus.dbus_rsp_data  = (bus.dbus_rsp_ready && (state == WAIT_RSP)) ? bus.mem_rsp_rdata : 32'd0;
  end

endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// Directed bench for vexriscv_bus_arbiter with a response scoreboard and a
// small memory responder; honours BUS_ARB_RR_EN for the arbitration order.
module tb_vexriscv_bus_arbiter;
  import vexriscv_soc_pkg::*;

  localparam int MEM_AW = 20;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        is_ibus;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  vexriscv_bus_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

  vexriscv_bus_arbiter #(.MEM_AW(MEM_AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  rsp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        rsp_en = 1'b1;
  logic        inject_rsp = 1'b0;
  logic        model_rsp_valid = 1'b0;
  logic [31:0] model_rdata = 32'd0;

  assign bus.mem_rsp_valid = model_rsp_valid | inject_rsp;
  assign bus.mem_rsp_rdata = model_rdata;

  function automatic logic [31:0] rd_word(logic [MEM_AW-1:0] a);
    return (a == 20'h4) ? 32'h0000_0013 : {16'hC0DE, a[15:0]};
  endfunction

  // Memory answers every accepted read on the following cycle.
  always @(posedge clk) begin
    model_rsp_valid <= rsp_en && bus.mem_cmd_valid && bus.mem_cmd_ready && !bus.mem_cmd_wr;
    model_rdata     <= rd_word(bus.mem_cmd_addr);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Response monitor, sampled well after the falling edge.
  initial begin
    rsp_t e;
    logic ib;
    forever begin
      @(negedge clk);
      #3;
      if (reset_n && (bus.ibus_rsp_valid || bus.dbus_rsp_ready)) begin
        ib = bus.ibus_rsp_valid;
        chk1("dual_rsp", bus.ibus_rsp_valid & bus.dbus_rsp_ready, 1'b0);
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", {30'd0, bus.ibus_rsp_valid, bus.dbus_rsp_ready}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk1("rsp_owner", ib, e.is_ibus);
          chk1("rsp_err", ib ? bus.ibus_rsp_error : bus.dbus_rsp_error, e.err);
          chk("rsp_data", ib ? bus.ibus_rsp_inst : bus.dbus_rsp_data, e.data);
          $display("rsp  %s err=%b data=%h", ib ? "ibus" : "dbus",
                   ib ? bus.ibus_rsp_error : bus.dbus_rsp_error,
                   ib ? bus.ibus_rsp_inst : bus.dbus_rsp_data);
        end
      end
    end
  end

  task automatic drive_d(logic v, logic wr, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
    bus.dbus_cmd_valid   = v;
    bus.dbus_cmd_wr      = wr;
    bus.dbus_cmd_address = a;
    bus.dbus_cmd_size    = sz;
    bus.dbus_cmd_data    = d;
  endtask

  task automatic drive_i(logic v, logic [31:0] pc);
    bus.ibus_cmd_valid = v;
    bus.ibus_cmd_pc    = pc;
  endtask

  task automatic idle_bus();
    drive_d(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    drive_i(1'b0, 32'd0);
  endtask

  task automatic arb_run(int n);
    logic exp_d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_d(1'b1, 1'b0, 32'h30, 2'd2, 32'd0);
      drive_i(1'b1, 32'h20);
      #1;
      exp_d = RR ? ((k % 2) == 0) : 1'b1;
      chk1("arb_grant_d", bus.dbus_cmd_ready, exp_d);
      chk1("arb_grant_i", bus.ibus_cmd_ready, ~exp_d);
      chk("arb_addr", 32'(bus.mem_cmd_addr), exp_d ? 32'hC : 32'h8);
      sb_q.push_back('{~exp_d, 1'b0, exp_d ? 32'hC0DE_000C : 32'hC0DE_0008});
      $display("cmd  arb grant=%s", exp_d ? "dbus" : "ibus");
      @(negedge clk);
      #1;
      chk("arb_wait_ready", {30'd0, bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 32'd0);
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd_ok(logic is_i, logic [31:0] a, logic [31:0] exp_waddr, logic [31:0] exp_data);
    @(negedge clk);
    if (is_i) drive_i(1'b1, a);
    else drive_d(1'b1, 1'b0, a, 2'd2, 32'd0);
    #1;
    chk1("rd_cmd_ready", is_i ? bus.ibus_cmd_ready : bus.dbus_cmd_ready, 1'b1);
    chk1("rd_mem_valid", bus.mem_cmd_valid, 1'b1);
    chk1("rd_mem_wr", bus.mem_cmd_wr, 1'b0);
    chk("rd_mem_addr", 32'(bus.mem_cmd_addr), exp_waddr);
    chk("rd_mem_mask", 32'(bus.mem_cmd_mask), 32'hF);
    sb_q.push_back('{is_i, 1'b0, exp_data});
    $display("cmd  read %s addr=%h", is_i ? "ibus" : "dbus", a);
    @(negedge clk);
    idle_bus();
    #1;
    chk("rd_busy_ready", {30'd0, bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("rd_single_pulse", {30'd0, bus.ibus_rsp_valid, bus.dbus_rsp_ready}, 32'd0);
  endtask

  task automatic wr_chk(logic [31:0] a, logic [1:0] sz, logic [31:0] d,
                        logic [3:0] exp_mask, logic [31:0] exp_waddr, logic [31:0] exp_wdata);
    @(negedge clk);
    drive_d(1'b1, 1'b1, a, sz, d);
    #1;
    chk1("wr_cmd_ready", bus.dbus_cmd_ready, 1'b1);
    chk1("wr_mem_valid", bus.mem_cmd_valid, 1'b1);
    chk1("wr_mem_wr", bus.mem_cmd_wr, 1'b1);
    chk("wr_mem_mask", 32'(bus.mem_cmd_mask), 32'(exp_mask));
    chk("wr_mem_addr", 32'(bus.mem_cmd_addr), exp_waddr);
    chk("wr_mem_wdata", bus.mem_cmd_wdata, exp_wdata);
    $display("cmd  write addr=%h size=%0d data=%h", a, sz, d);
    @(negedge clk);
    idle_bus();
    #1;
    chk1("wr_no_rsp", bus.dbus_rsp_ready, 1'b0);
  endtask

  task automatic err_read(logic is_i, logic [31:0] a, logic [1:0] sz);
    @(negedge clk);
    bus.mem_cmd_ready = 1'b0;
    if (is_i) drive_i(1'b1, a);
    else drive_d(1'b1, 1'b0, a, sz, 32'd0);
    #1;
    chk1("err_cmd_ready", is_i ? bus.ibus_cmd_ready : bus.dbus_cmd_ready, 1'b1);
    chk1("err_no_mem_cmd", bus.mem_cmd_valid, 1'b0);
    sb_q.push_back('{is_i, 1'b1, 32'd0});
    $display("cmd  bad read %s addr=%h size=%0d", is_i ? "ibus" : "dbus", a, sz);
    @(negedge clk);
    idle_bus();
    bus.mem_cmd_ready = 1'b1;
    #1;
    chk("err_busy_ready", {30'd0, bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 32'd0);
  endtask

  initial begin
    bus.mem_cmd_ready = 1'b1;
    drive_d(1'b1, 1'b0, 32'h30, 2'd2, 32'd0);
    drive_i(1'b1, 32'h20);
    #2 reset_n = 1'b0;

    // Outputs stay quiet in reset even with both requesters asking.
    @(negedge clk);
    #1;
    chk("reset_cmd_ready", {30'd0, bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 32'd0);
    chk1("reset_mem_valid", bus.mem_cmd_valid, 1'b0);
    chk("reset_rsp_valid", {30'd0, bus.ibus_rsp_valid, bus.dbus_rsp_ready}, 32'd0);
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;

    arb_run(4);

    rd_ok(1'b1, 32'h10, 32'h4, 32'h0000_0013);
    rd_ok(1'b0, 32'h003F_FFFC, 32'hF_FFFF, 32'hC0DE_FFFF);

    wr_chk(32'h103, 2'd0, 32'h0000_00AB, 4'b1000, 32'h40, 32'hABAB_ABAB);
    wr_chk(32'h102, 2'd1, 32'h0000_1234, 4'b1100, 32'h40, 32'h1234_1234);
    wr_chk(32'h100, 2'd0, 32'h0000_00CD, 4'b0001, 32'h40, 32'hCDCD_CDCD);

    err_read(1'b0, 32'h102, 2'd2);
    err_read(1'b1, 32'h12, 2'd2);
    err_read(1'b0, 32'h0040_0000, 2'd2);
    err_read(1'b0, 32'h100, 2'd3);
    err_read(1'b0, 32'h101, 2'd1);

    // A faulty write is dropped and leaves the arbiter idle for the next fetch.
    @(negedge clk);
    drive_d(1'b1, 1'b1, 32'h101, 2'd1, 32'h5555);
    #1;
    chk1("errwr_cmd_ready", bus.dbus_cmd_ready, 1'b1);
    chk1("errwr_no_mem_cmd", bus.mem_cmd_valid, 1'b0);
    $display("cmd  bad write addr=101 size=1");
    @(negedge clk);
    idle_bus();
    rd_ok(1'b1, 32'h14, 32'h5, 32'hC0DE_0005);

    // Memory back-pressure: command held for three cycles, taken on the fourth.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.mem_cmd_ready = 1'b0;
      drive_d(1'b1, 1'b0, 32'h200, 2'd2, 32'd0);
      #1;
      chk1("stall_cmd_ready", bus.dbus_cmd_ready, 1'b0);
      chk1("stall_mem_valid", bus.mem_cmd_valid, 1'b1);
      chk("stall_mem_addr", 32'(bus.mem_cmd_addr), 32'h80);
    end
    @(negedge clk);
    bus.mem_cmd_ready = 1'b1;
    #1;
    chk1("stall_accept", bus.dbus_cmd_ready, 1'b1);
    sb_q.push_back('{1'b0, 1'b0, 32'hC0DE_0080});
    $display("cmd  read dbus addr=200 after stall");
    @(negedge clk);
    idle_bus();

    // Reset in the middle of an outstanding read.
    @(negedge clk);
    rsp_en = 1'b0;
    drive_d(1'b1, 1'b0, 32'h30, 2'd2, 32'd0);
    #1;
    chk1("rst_rd_accept", bus.dbus_cmd_ready, 1'b1);
    $display("cmd  read dbus addr=30, reset before response");
    @(negedge clk);
    drive_d(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    drive_i(1'b1, 32'h10);
    #1;
    chk1("rst_wait_ready", bus.ibus_cmd_ready, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", {30'd0, bus.ibus_cmd_ready, bus.dbus_cmd_ready}, 32'd0);
    chk1("rst_mem_valid", bus.mem_cmd_valid, 1'b0);
    chk("rst_rsp_valid", {30'd0, bus.ibus_rsp_valid, bus.dbus_rsp_ready}, 32'd0);
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;
    rsp_en = 1'b1;
    inject_rsp = 1'b1;
    #1;
    chk("late_rsp_ignored", {30'd0, bus.ibus_rsp_valid, bus.dbus_rsp_ready}, 32'd0);
    @(negedge clk);
    inject_rsp = 1'b0;

    arb_run(2);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vexriscv_bus_arbiter.md
VEXRISCV_BUS_ARBITER -- requirements
Module: vexriscv_bus_arbiter

Interface
REQ-001 SHALL have parameter: MEM_AW, 20, word-address width of the shared memory (2^MEM_AW 32-bit words).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ibus_cmd_valid in 1 / ibus_cmd_ready out 1 / ibus_cmd_pc in 32  instruction fetch request.
REQ-005 SHALL have ports: ibus_rsp_valid out 1 / ibus_rsp_error out 1 / ibus_rsp_inst out 32  fetch response.
REQ-006 SHALL have ports: dbus_cmd_valid in 1 / dbus_cmd_ready out 1 / dbus_cmd_wr in 1 / dbus_cmd_address in 32 / dbus_cmd_data in 32 / dbus_cmd_size in 2  data request.
REQ-007 SHALL have ports: dbus_rsp_ready out 1 / dbus_rsp_error out 1 / dbus_rsp_data out 32  data read response.
REQ-008 SHALL have ports: mem_cmd_valid out 1 / mem_cmd_ready in 1 / mem_cmd_wr out 1 / mem_cmd_addr out MEM_AW / mem_cmd_wdata out 32 / mem_cmd_mask out 4  shared single-port memory request.
REQ-009 SHALL have ports: mem_rsp_valid in 1 / mem_rsp_rdata in 32  memory read data, one pulse per accepted read.

Function
REQ-010 SHALL share one memory port between iBus and dBus; at most one read outstanding.
REQ-011 SHALL implement FSM IDLE, WAIT_RSP, ERR_RSP; IDLE grants a command; accepted read -> WAIT_RSP; error -> ERR_RSP; write accepted -> stays IDLE.
REQ-012 SHALL assert cmd_ready to the granted requester only, combinationally equal to mem_cmd_ready in IDLE (1 in IDLE for error commands), 0 in WAIT_RSP/ERR_RSP.
REQ-013 SHALL without BUS_ARB_RR_EN give dBus fixed priority when both valid in IDLE.
REQ-014 SHALL drive mem_cmd_addr = address[MEM_AW+1:2], mem_cmd_wr = dbus_cmd_wr for dBus, 0 for iBus; mask 4'hF for iBus.
REQ-015 SHALL form dBus mask: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'hF; wdata byte/halfword replicated across lanes.
REQ-016 SHALL flag error (no mem_cmd_valid) for: size 3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0; iBus pc[1:0]!=0; any address bit above MEM_AW+1 set.
REQ-017 SHALL for error reads return rsp with error=1, data=0, one cycle after accept (ERR_RSP); error writes dropped silently, no response.
REQ-018 SHALL in WAIT_RSP route mem_rsp_valid to the registered owner: ibus_rsp_valid or dbus_rsp_ready = 1 for exactly that cycle, data = mem_rsp_rdata, error = 0, then IDLE.
REQ-019 SHALL produce no response for writes.
REQ-020 SHALL hold all rsp valids 0 except in the delivering cycle; rsp data registered passthrough allowed only from mem_rsp_rdata/0.
REQ-021 SHALL ignore mem_rsp_valid in IDLE/ERR_RSP.

Reset
REQ-022 SHALL on reset_n low asynchronously enter IDLE, clear owner, RR pointer to dBus-first, all valid/ready outputs 0.
REQ-023 SHALL discard any outstanding read on reset mid-operation; late mem_rsp_valid after release ignored per REQ-021.

Configuration
REQ-024 SHALL with BUS_ARB_RR_EN defined use round-robin: on conflict grant the requester not granted last; pointer updates only on accept.
REQ-025 SHALL without BUS_ARB_RR_EN use fixed dBus priority (REQ-013); no pointer register.

Structure
REQ-026 SHALL place FSM state enum, size encodings (BYTE/HALF/WORD) and owner encoding in shared package vexriscv_soc_pkg.
REQ-027 SHALL factor mask/alignment/range check into sub-module vexriscv_bus_lanes (combinational).

Verification
REQ-028 SHALL cover: iBus read pc=0x10, memory returns 0x00000013 next cycle -> ibus_rsp_valid 1 cycle, inst=0x00000013.
REQ-029 SHALL cover: dBus byte write addr=0x103, data=0xAB -> mask 4'b1000, addr=0x40, wdata=0xABABABAB, no response.
REQ-030 SHALL cover: both valid in IDLE continuously -> fixed mode: dBus always wins; RR mode: grants alternate D,I,D,I.
REQ-031 SHALL cover: dBus size 2 read at 0x102 -> no mem_cmd_valid, dbus_rsp_ready=1, error=1, data=0 next cycle.
REQ-032 SHALL cover: mem_cmd_ready=0 for 3 cycles -> requester ready 0, command held, accepted on 4th.
REQ-033 SHALL cover: reset_n low during WAIT_RSP -> outputs 0 immediately; mem_rsp_valid after release yields no response.
